rom_frame_reader: RTL and testbench

Sequencing controller for the single-port frame ROM that holds the 320x240 8-bit source image. It walks ROM addresses in row-major order, drives the ROM enable, read-enable and address inputs, and absorbs the ROM's 1-cycle registered read latency. It presents the pixels as a valid/ready stream with start-of-frame, end-of-line and end-of-frame tags to the downstream Sobel/VGA pipeline. It supports single-shot and continuous (free-running) frame modes.

---
 rtl/rom_frame_reader.sv | 151 +++++++++++++++
 tb/tb_rom_frame_reader.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_frame_reader.sv
// Row-major frame ROM sequencer: issues one ROM read per cycle, absorbs the
// 1-cycle read latency in a 2-entry skid FIFO and emits a tagged valid/ready pixel stream.
module rom_frame_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk_i_rdr,
    input  logic                  rst_i_rdr,
    input  logic                  start_i_rdr,
    input  logic                  cont_i_rdr,
    input  logic                  abort_i_rdr,
    output logic                  rom_en_o,
    output logic                  rom_re_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  pix_sof_o,
    output logic                  pix_eol_o,
    output logic                  pix_eof_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0]         X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]         Y_LAST = YW'(IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] A_BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  inflight;
    logic [2:0]            tag_q;
    entry_t                fifo [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic                  done;

    logic                  pop;
    logic [2:0]            pend;
    logic                  issue;
    logic                  last_pix;
    entry_t                head;

    // A read is only issued if its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        pop      = (occ != 2'd0) && pix_ready_i;
        pend     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        issue    = (state == ST_RUN) && (pend < 3'd2);
        last_pix = (x == X_LAST) && (y == Y_LAST);
    end

    always_ff @(posedge clk_i_rdr) begin
        if (rst_i_rdr || abort_i_rdr) begin
            state    <= ST_IDLE;
            addr     <= '0;
            x        <= '0;
            y        <= '0;
            inflight <= 1'b0;
            tag_q    <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= '0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (inflight) begin
                fifo[wr_ptr] <= {rom_data_i, tag_q};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};

            if (issue) begin
                tag_q <= {(x == '0) && (y == '0), x == X_LAST, last_pix};
                addr  <= addr + 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start_i_rdr) begin
                        state <= ST_RUN;
                        addr  <= A_BASE;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue && last_pix)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((occ == 2'd0) && !inflight) begin
                        if (cont_i_rdr) begin
                            state <= ST_RUN;
                            addr  <= A_BASE;
                            x     <= '0;
                            y     <= '0;
                        end else begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        head = pix_valid_o ? fifo[rd_ptr] : '0;
    end

    assign rom_en_o    = (state != ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign rom_re_o    = issue;
    assign rom_addr_o  = addr;
    assign pix_valid_o = (occ != 2'd0);
    assign pix_data_o  = head.data;
    assign pix_sof_o   = head.sof;
    assign pix_eol_o   = head.eol;
    assign pix_eof_o   = head.eof;
    assign done_o      = done;

    capture_no_overflow: assert property (@(posedge clk_i_rdr)
        disable iff (rst_i_rdr || abort_i_rdr) !(inflight && !pop && (occ == 2'd2)));
endmodule

// File: tb/tb_rom_frame_reader.sv
// Bench for rom_frame_reader on a 4x3 frame; the ROM returns addr[7:0] one cycle after a read.
module tb_rom_frame_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 17;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned N  = W * H;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst, start, cont, abort, pix_ready;
    logic          rom_en, rom_re, pix_valid, sof, eol, eof, busy, done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, pix_data;

    int   tests = 0;
    int   fails = 0;

    pix_t obs_q [$];
    int   obs_cyc [$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   stab_err = 0;
    int   issued = 0;
    int   popped = 0;
    int   max_out = 0;
    logic hold_chk = 1'b0;
    pix_t prev_pix = '0;
    pix_t cur_pix;

    always #5 clk = ~clk;

    rom_frame_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H), .BASE_ADDR(0)
    ) dut (
        .clk_i_rdr(clk), .rst_i_rdr(rst), .start_i_rdr(start), .cont_i_rdr(cont),
        .abort_i_rdr(abort), .rom_en_o(rom_en), .rom_re_o(rom_re), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .pix_data_o(pix_data), .pix_valid_o(pix_valid),
        .pix_ready_i(pix_ready), .pix_sof_o(sof), .pix_eol_o(eol), .pix_eof_o(eof),
        .busy_o(busy), .done_o(done)
    );

    always_ff @(posedge clk) begin
        if (rom_en && rom_re)
            rom_data <= rom_addr[7:0];
    end

    // Stream monitor: records handshakes, done pulses, hold violations and outstanding reads.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            cur_pix = {pix_data, sof, eol, eof};
            if (rst) begin
                hold_chk = 1'b0;
                issued   = 0;
                popped   = 0;
            end else begin
                if (pix_valid && pix_ready) begin
                    obs_q.push_back(cur_pix);
                    obs_cyc.push_back(cyc);
                end
                if (done)
                    done_cnt++;
                if (hold_chk && (!pix_valid || cur_pix != prev_pix))
                    stab_err++;
                hold_chk = pix_valid && !pix_ready && !abort;
                prev_pix = cur_pix;
                if (!busy) begin
                    issued = 0;
                    popped = 0;
                end else begin
                    issued += int'(rom_re);
                    popped += int'(pix_valid && pix_ready);
                    if (issued - popped > max_out)
                        max_out = issued - popped;
                end
            end
        end
    end

    function automatic pix_t exp_pix(input int i);
        int   p = i % N;
        pix_t e;
        e.d   = 8'(p);
        e.sof = (p == 0);
        e.eol = ((p % W) == (W - 1));
        e.eof = (p == N - 1);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if ({rom_en, rom_re, rom_addr, pix_valid, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got en=%b re=%b addr=%h valid=%b busy=%b done=%b, expected all 0",
                     rom_en, rom_re, rom_addr, pix_valid, busy, done);
        end
        tests++;
        if ({pix_data, sof, eol, eof} !== '0) begin
            fails++;
            $display("FAIL reset_stream: got data=%h sof=%b eol=%b eof=%b, expected all 0", pix_data, sof, eol, eof);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int   base, dbase, n, gaps;
        logic ok;
        pix_ready = 1'b1;
        cont      = 1'b0;
        base      = obs_q.size();
        dbase     = done_cnt;
        tick();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        tests++;
        if ({rom_re, rom_addr, busy, pix_valid} !== {1'b1, 17'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL lat_cycle1: got re=%b addr=%h busy=%b valid=%b, expected 1 0 1 0", rom_re, rom_addr, busy, pix_valid);
        end
        @(negedge clk);
        tests++;
        if (pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_cycle2: got valid=%b, expected 0", pix_valid);
        end
        @(negedge clk);
        tests++;
        if ({pix_valid, pix_data, sof} !== {1'b1, 8'd0, 1'b1}) begin
            fails++;
            $display("FAIL lat_cycle3: got valid=%b data=%h sof=%b, expected 1 00 1", pix_valid, pix_data, sof);
        end
        wait_done(100, ok);
        tests++;
        if (!ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got done_seen=%b busy=%b, expected 1 0", ok, busy);
        end
        tick();
        n = obs_q.size() - base;
        tests++;
        if (n != N) begin
            fails++;
            $display("FAIL single_count: got %0d pixels, expected %0d", n, N);
        end
        for (int i = 0; i < n && i < int'(N); i++) begin
            tests++;
            if (obs_q[base+i] !== exp_pix(i)) begin
                fails++;
                $display("FAIL single_pix[%0d]: got %h, expected %h", i, obs_q[base+i], exp_pix(i));
            end
        end
        gaps = 0;
        for (int i = 1; i < n; i++)
            if (obs_cyc[base+i] != obs_cyc[base+i-1] + 1)
                gaps++;
        tests++;
        if (gaps != 0) begin
            fails++;
            $display("FAIL single_throughput: got %0d gaps, expected 0", gaps);
        end
        tests++;
        if (done_cnt - dbase != 1) begin
            fails++;
            $display("FAIL single_done_pulse: got %0d done cycles, expected 1", done_cnt - dbase);
        end
    endtask

    task automatic test_backpressure();
        int   base, sbase, n, bad_hold, bad_re;
        logic stalled, ok;
        pix_ready = 1'b1;
        base      = obs_q.size();
        sbase     = stab_err;
        stalled   = 1'b0;
        start_frame();
        for (int c = 0; c < 200 && !stalled; c++) begin
            tick();
            if (pix_valid && pix_data == 8'd5) begin
                pix_ready = 1'b0;
                stalled   = 1'b1;
            end
        end
        tests++;
        if (!stalled) begin
            fails++;
            $display("FAIL bp_reach5: got no pixel 5 at head, expected within 200 cycles");
        end
        bad_hold = 0;
        bad_re   = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!pix_valid || pix_data !== 8'd5)
                bad_hold++;
            if (k >= 1 && rom_re)
                bad_re++;
        end
        tests++;
        if (bad_hold != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d cycles without valid pixel 5, expected 0", bad_hold);
        end
        tests++;
        if (bad_re != 0) begin
            fails++;
            $display("FAIL bp_re_stop: got %0d read cycles during stall, expected 0", bad_re);
        end
        tick();
        pix_ready = 1'b1;
        wait_done(100, ok);
        tick();
        n = obs_q.size() - base;
        tests++;
        if (!ok || n != N) begin
            fails++;
            $display("FAIL bp_count: got done=%b pixels=%0d, expected 1 %0d", ok, n, N);
        end
        for (int i = 0; i < n && i < int'(N); i++) begin
            tests++;
            if (obs_q[base+i] !== exp_pix(i)) begin
                fails++;
                $display("FAIL bp_pix[%0d]: got %h, expected %h", i, obs_q[base+i], exp_pix(i));
            end
        end
        tests++;
        if (stab_err != sbase || max_out > 2) begin
            fails++;
            $display("FAIL bp_stability: got hold_errs=%0d max_outstanding=%0d, expected 0 and <=2", stab_err - sbase, max_out);
        end
    endtask

    task automatic test_continuous();
        int   base, dbase, n, after;
        logic ok;
        pix_ready = 1'b1;
        cont      = 1'b1;
        base      = obs_q.size();
        dbase     = done_cnt;
        start_frame();
        for (int c = 0; c < 300 && obs_q.size() < base + 18; c++)
            tick();
        cont = 1'b0;
        wait_done(200, ok);
        tick();
        n = obs_q.size() - base;
        tests++;
        if (!ok || n != 2 * N) begin
            fails++;
            $display("FAIL cont_count: got done=%b pixels=%0d, expected 1 %0d", ok, n, 2 * N);
        end
        for (int i = 0; i < n && i < int'(2 * N); i++) begin
            tests++;
            if (obs_q[base+i] !== exp_pix(i)) begin
                fails++;
                $display("FAIL cont_pix[%0d]: got %h, expected %h", i, obs_q[base+i], exp_pix(i));
            end
        end
        tests++;
        if (done_cnt - dbase != 1) begin
            fails++;
            $display("FAIL cont_done: got %0d done cycles, expected 1", done_cnt - dbase);
        end
        after = obs_q.size();
        for (int k = 0; k < 10; k++)
            tick();
        tests++;
        if (obs_q.size() != after || busy !== 1'b0) begin
            fails++;
            $display("FAIL cont_stop: got extra=%0d busy=%b, expected 0 0", obs_q.size() - after, busy);
        end
    endtask

    task automatic test_abort();
        int   base, dbase, n, bad;
        logic found, ok;
        cont  = 1'b0;
        base  = obs_q.size();
        dbase = done_cnt;
        found = 1'b0;
        pix_ready = 1'b1;
        start_frame();
        for (int c = 0; c < 300 && !found; c++) begin
            tick();
            pix_ready = 1'($urandom_range(0, 1));
            if (pix_valid && pix_data == 8'd6) begin
                abort = 1'b1;
                found = 1'b1;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL abort_reach6: got no pixel 6 at head, expected within 300 cycles");
        end
        tick();
        abort = 1'b0;
        tests++;
        if ({pix_valid, rom_re, rom_en, busy, done} !== 5'b0) begin
            fails++;
            $display("FAIL abort_flush: got valid=%b re=%b en=%b busy=%b done=%b, expected all 0",
                     pix_valid, rom_re, rom_en, busy, done);
        end
        for (int k = 0; k < 5; k++)
            tick();
        n   = obs_q.size() - base;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (obs_q[base+i] !== exp_pix(i))
                bad++;
        tests++;
        if (bad != 0 || n > 7 || done_cnt != dbase) begin
            fails++;
            $display("FAIL abort_prefix: got pixels=%0d out_of_order=%0d done=%0d, expected <=7 0 0", n, bad, done_cnt - dbase);
        end
        pix_ready = 1'b1;
        base = obs_q.size();
        start_frame();
        wait_done(100, ok);
        tick();
        n = obs_q.size() - base;
        tests++;
        if (!ok || n != N || obs_q[base] !== exp_pix(0)) begin
            fails++;
            $display("FAIL abort_restart: got done=%b pixels=%0d first=%h, expected 1 %0d %h",
                     ok, n, (n > 0) ? obs_q[base] : pix_t'('0), N, exp_pix(0));
        end
    endtask

    task automatic test_reset_midframe();
        int   base, n, bad;
        logic ok;
        pix_ready = 1'b1;
        base      = obs_q.size();
        start_frame();
        for (int c = 0; c < 200 && obs_q.size() < base + 4; c++)
            tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({rom_en, rom_re, rom_addr, pix_valid, pix_data, sof, eol, eof, busy, done} !== '0) begin
            fails++;
            $display("FAIL rst_mid: got en=%b re=%b addr=%h valid=%b data=%h busy=%b done=%b, expected all 0",
                     rom_en, rom_re, rom_addr, pix_valid, pix_data, busy, done);
        end
        base = obs_q.size();
        tick();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        tests++;
        if ({rom_re, rom_addr} !== {1'b1, 17'd0}) begin
            fails++;
            $display("FAIL rst_restart_addr: got re=%b addr=%h, expected 1 0", rom_re, rom_addr);
        end
        wait_done(100, ok);
        tick();
        n   = obs_q.size() - base;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (obs_q[base+i] !== exp_pix(i))
                bad++;
        tests++;
        if (!ok || n != N || bad != 0) begin
            fails++;
            $display("FAIL rst_restart_frame: got done=%b pixels=%0d bad=%0d, expected 1 %0d 0", ok, n, bad, N);
        end
    endtask

    task automatic test_start_while_busy();
        int   base, dbase, n, bad;
        logic ok;
        pix_ready = 1'b1;
        base      = obs_q.size();
        dbase     = done_cnt;
        start_frame();
        for (int c = 0; c < 200 && obs_q.size() < base + 8; c++) begin
            tick();
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        wait_done(100, ok);
        for (int k = 0; k < 10; k++)
            tick();
        n   = obs_q.size() - base;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (obs_q[base+i] !== exp_pix(i))
                bad++;
        tests++;
        if (!ok || n != N || bad != 0 || busy !== 1'b0 || done_cnt - dbase != 1) begin
            fails++;
            $display("FAIL start_busy: got done=%b pixels=%0d bad=%0d busy=%b dones=%0d, expected 1 %0d 0 0 1",
                     ok, n, bad, busy, done_cnt - dbase, N);
        end
    endtask

    task automatic test_random_backpressure();
        int   base, sbase, dbase, n;
        logic seen;
        base  = obs_q.size();
        sbase = stab_err;
        dbase = done_cnt;
        cont  = 1'b1;
        seen  = 1'b0;
        pix_ready = 1'b1;
        start_frame();
        for (int c = 0; c < 800 && !seen; c++) begin
            tick();
            pix_ready = 1'($urandom_range(0, 1));
            if (obs_q.size() >= base + 14)
                cont = 1'b0;
            if (done)
                seen = 1'b1;
        end
        pix_ready = 1'b1;
        tick();
        n = obs_q.size() - base;
        tests++;
        if (!seen || n != 2 * N) begin
            fails++;
            $display("FAIL rnd_count: got done=%b pixels=%0d, expected 1 %0d", seen, n, 2 * N);
        end
        for (int i = 0; i < n && i < int'(2 * N); i++) begin
            tests++;
            if (obs_q[base+i] !== exp_pix(i)) begin
                fails++;
                $display("FAIL rnd_pix[%0d]: got %h, expected %h", i, obs_q[base+i], exp_pix(i));
            end
        end
        tests++;
        if (stab_err != sbase || max_out > 2 || done_cnt - dbase != 1) begin
            fails++;
            $display("FAIL rnd_protocol: got hold_errs=%0d max_outstanding=%0d dones=%0d, expected 0 <=2 1",
                     stab_err - sbase, max_out, done_cnt - dbase);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_continuous();
        test_abort();
        test_reset_midframe();
        test_start_while_busy();
        test_random_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
